// File: rtl/xor_pkg.sv
// Shared constants, state encoding and LFSR step function for the XOR descrambler.
package xor_pkg;

    localparam logic [7:0] LFSR_POLY    = 8'h1D;
    localparam logic [7:0] LFSR_DEFAULT = 8'h01;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One Galois step of x^8+x^4+x^3+x^2+1 (period 255 from any non-zero state).
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? LFSR_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/xor_lfsr8.sv
// 8-bit Galois LFSR keystream generator.
// Ports: clk, rst (sync, active-high), load/load_val (seed; zero maps to
// LFSR_DEFAULT so the register never locks up), step (advance one state),
// state (current keystream byte).
module xor_lfsr8
    import xor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       step,
    output logic [7:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_DEFAULT;
        end else if (load) begin
            state <= (load_val == 8'h00) ? LFSR_DEFAULT : load_val;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/xor_descrambler.sv
// XOR descrambler: each accepted byte is XORed with an LFSR keystream and
// presented on a one-deep valid/ready output register (1 byte/cycle).
// Ports: clk, rst (sync, active-high), seed_load/seed (start or restart the
// stream), in_valid/in_data/in_ready (input handshake), out_valid/out_data/
// out_ready (output handshake), byte_count (bytes accepted since seed_load).
// Optional macro PARITY_CHECK_EN adds in_parity (even parity of plaintext)
// and the sticky parity_err flag.
module xor_descrambler
    import xor_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_load,
    input  logic [7:0]         seed,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] byte_count
`ifdef PARITY_CHECK_EN
    ,
    input  logic               in_parity,
    output logic               parity_err
`endif
);

    state_t     state_q;
    logic [7:0] keystream;
    logic       accept;

    // Ready whenever the output slot is empty or draining; never while reseeding.
    assign in_ready = (state_q == RUN) && !seed_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    xor_lfsr8 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_load),
        .load_val (seed),
        .step     (accept),
        .state    (keystream)
    );

    // State, output register and accepted-byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            byte_count <= '0;
        end else if (seed_load) begin
            state_q    <= RUN;
            out_valid  <= 1'b0;
            byte_count <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= in_data ^ keystream;
            byte_count <= byte_count + COUNT_W'(1);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_q;

    // Parity travels with its byte; mismatch is checked while the byte is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q      <= 1'b0;
            parity_err <= 1'b0;
        end else if (seed_load) begin
            parity_err <= 1'b0;
        end else begin
            if (accept) begin
                par_q <= in_parity;
            end
            if (out_valid && ((^out_data) != par_q)) begin
                parity_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xor_descrambler.sv
// Self-checking bench for xor_descrambler: directed vectors, expected bytes
// queued by the driver and checked by an independent output monitor.
module tb_xor_descrambler;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          seed_load = 1'b0;
    logic [7:0]    seed = 8'h00;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready = 1'b1;
    logic [CW-1:0] byte_count;
`ifdef PARITY_CHECK_EN
    logic          in_parity = 1'b0;
    logic          parity_err;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] dropped;

    // Hand-computed keystream from seed 8'h01 (also what seed 8'h00 must give).
    logic [7:0] ks [0:15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26};

    xor_descrambler #(.COUNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed       (seed),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .byte_count (byte_count)
`ifdef PARITY_CHECK_EN
        ,
        .in_parity  (in_parity),
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: every presented-and-taken byte must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Called just after a posedge; returns just after the posedge that accepted the byte.
    task automatic send(input logic [7:0] d, input logic [7:0] e, input bit bad_par);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
`ifdef PARITY_CHECK_EN
        in_parity = (^e) ^ bad_par;
`else
        if (bad_par) in_data = d;
`endif
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic load(input logic [7:0] s);
        seed_load = 1'b1;
        seed      = s;
        @(negedge clk);
        check("in_ready_during_load", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    task automatic idle_check_count(input string name, input logic [CW-1:0] cnt);
        in_valid = 1'b0;
        @(negedge clk);
        check(name, 32'(byte_count), 32'(cnt));
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_byte_count", 32'(byte_count), 32'd0);
`ifdef PARITY_CHECK_EN
        check("rst_parity_err", 32'(parity_err), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // IDLE: input is refused without a seed
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 32'd0);
            check("idle_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Seed 01, three bytes back to back
        load(8'h01);
        send(8'h01, 8'h00, 0);
        send(8'hFF, 8'hFD, 0);
        send(8'h87, 8'h83, 0);
        idle_check_count("count_after_3", 4'd3);

        // Seed 00 behaves as 01; the ninth keystream byte is 1D
        load(8'h00);
        for (int i = 0; i < 9; i++) send(8'h00, ks[i], 0);
        idle_check_count("count_after_9", 4'd9);

        // Counter wrap at all-ones
        load(8'h01);
        for (int i = 0; i < 16; i++) send(8'hFF, ~ks[i], 0);
        idle_check_count("count_wrap", 4'd0);
`ifdef PARITY_CHECK_EN
        check("parity_err_clean", 32'(parity_err), 32'd0);
`endif

        // Back-pressure: output held three cycles, release accepts immediately
        load(8'h01);
        out_ready = 1'b0;
        send(8'hAA, 8'hAB, 0);
        in_valid = 1'b1;
        in_data  = 8'h10;
`ifdef PARITY_CHECK_EN
        in_parity = ^(8'h12);
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_data", 32'(out_data), 32'hAB);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back(8'h12);
        @(posedge clk); #1;
        idle_check_count("count_after_hold", 4'd2);

        // Reseed while a byte is pending: it is dropped, stream restarts at seed
        out_ready = 1'b0;
        send(8'h33, 8'h37, 0);
        seed_load = 1'b1;
        seed      = 8'h5A;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        @(negedge clk);
        check("reseed_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        seed_load = 1'b0;
        in_valid  = 1'b0;
        dropped   = exp_q.pop_back();
        @(negedge clk);
        check("reseed_out_valid", 32'(out_valid), 32'd0);
        check("reseed_byte_count", 32'(byte_count), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(8'h00, 8'h5A, 0);
        send(8'h00, 8'hB4, 0);
        idle_check_count("count_after_reseed", 4'd2);

`ifdef PARITY_CHECK_EN
        // Plaintext 03 has even parity 0; claim 1 and the flag must stick until reseed
        load(8'h01);
        send(8'h02, 8'h03, 1);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("parity_err_set", 32'(parity_err), 32'd1);
        @(posedge clk); #1;
        send(8'h12, 8'h10, 0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("parity_err_sticky", 32'(parity_err), 32'd1);
        @(posedge clk); #1;
        load(8'h01);
        @(negedge clk);
        check("parity_err_cleared", 32'(parity_err), 32'd0);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
